// File: rtl/gcd_host_sequencer.sv
// gcd_host_sequencer
//   Host-side initiator for a GCD core with a start/data_in/done interface.
//   Takes an operand pair on a valid/ready request port, serialises A then B
//   onto the core's shared input bus, waits for done (bounded by a timeout),
//   and returns the result on a valid/ready response port. Zero operands are
//   answered locally without involving the core.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake, req_a/req_b operands
//   rsp_valid/rsp_ready response handshake, rsp_gcd result, rsp_timeout abort flag
//   gcd_start           one-cycle start pulse to the core (A on the bus)
//   gcd_data            core data_in bus (A, then B, otherwise 0)
//   gcd_done/gcd_result core completion flag and result
//   busy                high whenever the sequencer is not idle
module gcd_host_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_timeout,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_e;

    // Counter value seen in the last permitted WAIT cycle; the edge ending
    // that cycle aborts if done is still low.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  gcd_q, gcd_d;
    logic              to_q, to_d;

    // State and holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            to_q    <= to_d;
        end
    end

    // Next-state and holding-register update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d = req_a;
                    b_d = req_b;
                    // gcd(0,x)=x and gcd(0,0)=0, so the OR is the answer.
                    if (req_a == '0 || req_b == '0) begin
                        gcd_d   = req_a | req_b;
                        to_d    = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (gcd_done) begin
                    gcd_d   = gcd_result;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    if (cnt_q == TO_LAST) begin
                        gcd_d   = '0;
                        to_d    = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and holding registers only
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        rsp_valid   = (state_q == S_RESP);
        rsp_gcd     = gcd_q;
        rsp_timeout = to_q;
        gcd_start   = (state_q == S_LOAD_A);
        gcd_data    = '0;
        if (state_q == S_LOAD_A) gcd_data = a_q;
        if (state_q == S_LOAD_B) gcd_data = b_q;
    end

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Scoreboard bench for gcd_host_sequencer: stimulus pushes the expected
// response (value, timeout flag, cycle of rsp_valid rise); a monitor pops and
// compares. A small core model checks the A/B bus sequence and answers done.
module tb_gcd_host_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_gcd;
    logic        rsp_timeout;
    logic        gcd_start;
    logic [15:0] gcd_data;
    logic        gcd_done = 1'b0;
    logic [15:0] gcd_result = '0;
    logic        busy;

    gcd_host_sequencer #(.WIDTH(16), .TIMEOUT(1023), .TO_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd),
        .rsp_timeout(rsp_timeout), .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] gcd;
        logic        to;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    // ---------------- core model ----------------
    logic [15:0] exp_a = '0, exp_b = '0, core_res = '0;
    int          core_n = 0;
    bit          start_exp = 0, glitch = 0;
    int          cd = 0;
    bit          in_load_b = 0;

    always @(negedge clk) begin
        if (in_load_b) begin
            chk("load_b_data", gcd_data, exp_b);
            chk("load_b_start", gcd_start, 0);
            gcd_done   = glitch;
            gcd_result = glitch ? 16'd999 : 16'd0;
            cd         = core_n;
            in_load_b  = 0;
        end else if (gcd_start) begin
            chk("start_expected", start_exp, 1);
            chk("load_a_data", gcd_data, exp_a);
            start_exp  = 0;
            in_load_b  = 1;
            gcd_done   = glitch;
            gcd_result = glitch ? 16'd999 : 16'd0;
        end else if (cd > 0) begin
            cd--;
            gcd_done   = (cd == 0);
            gcd_result = (cd == 0) ? core_res : 16'd0;
        end else begin
            gcd_done   = 1'b0;
            gcd_result = 16'd0;
        end
    end

    // ---------------- response monitor ----------------
    exp_t cur;
    bit   prev_v = 0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("req_ready_in_resp", req_ready, 0);
            if (!prev_v) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got gcd %0d to %0d, expected no response",
                             rsp_gcd, rsp_timeout);
                    cur = '{rsp_gcd, rsp_timeout, cyc};
                end else begin
                    cur = sbq.pop_front();
                    chk("rsp_cycle", cyc, cur.cyc);
                end
            end
            chk("rsp_gcd", rsp_gcd, cur.gcd);
            chk("rsp_timeout", rsp_timeout, cur.to);
        end
        prev_v = rsp_valid;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] g, input logic to, input int lat,
                        input int n, input logic [15:0] res, input bit gl);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++;
            $display("FAIL req_ready_wait: got 0 expected 1 within 3000 cycles");
            return;
        end
        exp_a = a; exp_b = b; core_n = n; core_res = res; glitch = gl;
        start_exp = (a != 0 && b != 0);
        req_a = a; req_b = b; req_valid = 1'b1;
        sbq.push_back('{g, to, cyc + lat});
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sbq.size() == 0 && !rsp_valid && req_ready) && k < 3000);
        if (k >= 3000) begin
            checks++;
            $display("FAIL drain: got %0d pending responses expected 0", sbq.size());
        end
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            checks++;
            $display("FAIL wait_rsp: got rsp_valid 0 expected 1 within 3000 cycles");
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_gcd"}, rsp_gcd, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_gcd_start"}, gcd_start, 0);
        chk({tag, "_gcd_data"}, gcd_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1'b1;

        // Core path, 20-cycle core: latency 3+20
        send(16'd143, 16'd78, 16'd13, 1'b0, 23, 20, 16'd13, 0);
        drain();

        // Back-pressure: response held stable while rsp_ready low
        rsp_ready = 1'b0;
        send(16'd48, 16'd18, 16'd6, 1'b0, 10, 7, 16'd6, 0);
        wait_rsp();
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("req_ready_after_hs", req_ready, 1);
        chk("rsp_valid_after_hs", rsp_valid, 0);

        // Zero-operand bypass, back to back
        send(16'd0, 16'd35, 16'd35, 1'b0, 1, 0, 16'd0, 0);
        send(16'd0, 16'd0, 16'd0, 1'b0, 1, 0, 16'd0, 0);
        send(16'd77, 16'd0, 16'd77, 1'b0, 1, 0, 16'd0, 0);
        drain();

        // Hung core: timeout after 1023 WAIT cycles, then a normal request
        send(16'd143, 16'd78, 16'd0, 1'b1, 3 + 1023, 0, 16'd0, 0);
        drain();
        send(16'd143, 16'd78, 16'd13, 1'b0, 7, 4, 16'd13, 0);
        drain();

        // Done pulsed during LOAD_A/LOAD_B with a bogus result is ignored
        send(16'd48, 16'd18, 16'd6, 1'b0, 8, 5, 16'd6, 1);
        drain();

        // Reset mid-WAIT; the core's late done must not produce a response
        send(16'd143, 16'd78, 16'd13, 1'b0, 33, 30, 16'd13, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete(sbq.size() - 1);
        @(negedge clk);
        chk_reset("rst_wait");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(16'd143, 16'd78, 16'd13, 1'b0, 23, 20, 16'd13, 0);
        drain();

        // Reset while a response is pending in RESP
        rsp_ready = 1'b0;
        send(16'd48, 16'd18, 16'd6, 1'b0, 10, 7, 16'd6, 0);
        wait_rsp();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_resp");
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(16'd143, 16'd78, 16'd13, 1'b0, 23, 20, 16'd13, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
Host-side initiator for the GCD core's `start`/`data_in`/`done` interface. It accepts an operand pair on an upstream valid/ready port and serialises the pair onto the core's shared 16-bit input bus: A on the `start` cycle, B on the following cycle. It then waits for `done`, captures the core's result and returns it on a downstream valid/ready port. It also handles zero operands locally and guards against a hung core with a timeout.

Parameters:
WIDTH, 16, operand/result width; matches the core's data_in.
TIMEOUT, 1023, max cycles in WAIT before aborting; must be >= 1.
TO_W, 10, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  operand pair valid
req_ready  output  1  sequencer can accept a pair
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accepts result
rsp_gcd  output  WIDTH  GCD result (0 on timeout)
rsp_timeout  output  1  result aborted by timeout
gcd_start  output  1  one-cycle start pulse to core
gcd_data  output  WIDTH  core data_in bus
gcd_done  input  1  core completion flag
gcd_result  input  WIDTH  core result bus, valid while gcd_done=1
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge) forces state to IDLE. It takes effect from any state, including mid-WAIT or in RESP with a pending response; the pending response is dropped.
- Reset values: req_ready=1, rsp_valid=0, rsp_gcd=0, rsp_timeout=0, gcd_start=0, gcd_data=0, busy=0, timeout counter=0.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge, A and B are latched.
  - If A=0 or B=0: go to RESP with rsp_gcd = A|B (gcd(0,x)=x, gcd(0,0)=0). No core transaction is launched.
  - Otherwise: go to LOAD_A.
- LOAD_A: gcd_start=1, gcd_data=A. Always go to LOAD_B next cycle.
- LOAD_B: gcd_start=0, gcd_data=B. Clear the counter. Go to WAIT.
- WAIT: gcd_data=0.
  - Each cycle with gcd_done=0, the counter increments.
  - gcd_done=1 at an edge: capture gcd_result into rsp_gcd, set rsp_timeout=0, go to RESP.
  - Counter reaching TIMEOUT with gcd_done still 0: set rsp_gcd=0, rsp_timeout=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_gcd and rsp_timeout are held stable until rsp_valid&rsp_ready at an edge, then go to IDLE.
  - req_ready=0 while in RESP, so a new request cannot be accepted in the same cycle the response is consumed. Minimum spacing between accepted requests is therefore: request cycle + 1 RESP cycle (bypass) or 4 cycles plus core time (core path).
- gcd_done is ignored in IDLE, LOAD_A, LOAD_B and RESP. A stale done cannot complete a transaction before B has been driven.
- Latency (request accepted at edge T, core asserts done N cycles after LOAD_B):
  - gcd_start high during cycle T+1.
  - B driven during cycle T+2.
  - rsp_valid rises at cycle T+3+N.
  - Bypass path: rsp_valid high in cycle T+1.
- All outputs are registered or decoded purely from state and holding registers, with no combinational path from req_* or rsp_ready.
- Widths: no arithmetic beyond the counter compare and the bypass OR. WIDTH-bit values pass through unmodified.

Test Plan:
- req A=143, B=78; core model asserts done with result 13 after 20 cycles -> gcd_start one cycle with gcd_data=143, next cycle gcd_data=78; rsp_valid with rsp_gcd=13, rsp_timeout=0 exactly 3+20 cycles after acceptance.
- req A=48, B=18, rsp_ready held low 5 cycles after rsp_valid -> rsp_gcd=6 held stable for all 5 cycles; req_ready stays 0 until the cycle after handshake.
- req A=0, B=35, then A=0, B=0 -> no gcd_start pulse; responses 35 and 0, each with rsp_valid one cycle after acceptance.
- Core never asserts done, TIMEOUT=1023 -> rsp_valid with rsp_gcd=0, rsp_timeout=1 at cycle 3+1023 after acceptance; next request proceeds normally.
- gcd_done pulsed high during LOAD_A and LOAD_B -> ignored; completion only on the later real done, with the correct result.
- rst_n driven low for 1 cycle mid-WAIT (and separately in RESP) -> all outputs return to reset values next cycle; a late core done is ignored; a fresh 143/78 request returns 13.
